// File: rtl/run_controller_pkg.sv
// run_ctrl_pkg
// Shared types and constants for the run controller: FSM state encoding,
// host command encoding and the two system instructions (ECALL/EBREAK)
// that stop the core.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_HALT = 2'b11
    } cmd_t;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    function automatic logic is_sys_instr(input logic [31:0] i);
        return (i == INSTR_ECALL) || (i == INSTR_EBREAK);
    endfunction

endpackage

// File: rtl/run_controller_if.sv
// run_controller_if
// Host-side bundle of the run controller: the command channel and the
// loader byte channel.
//   cmd_valid/cmd/cmd_ready   command handshake (LOAD/RUN/STEP/HALT)
//   ld_words                  word count, sampled with LOAD
//   ld_valid/ld_data/ld_ready loader byte handshake
// master = host/loader side, slave = run_controller side.
interface run_controller_if
    import run_ctrl_pkg::*;
#(
    parameter int IMEM_WORDS = 256
) ();
    localparam int LDW_W = $clog2(IMEM_WORDS) + 1;

    logic             cmd_valid;
    cmd_t             cmd;
    logic             cmd_ready;
    logic [LDW_W-1:0] ld_words;
    logic             ld_valid;
    logic [7:0]       ld_data;
    logic             ld_ready;

    modport master (
        output cmd_valid, cmd, ld_words, ld_valid, ld_data,
        input  cmd_ready, ld_ready
    );

    modport slave (
        input  cmd_valid, cmd, ld_words, ld_valid, ld_data,
        output cmd_ready, ld_ready
    );
endinterface

// File: rtl/run_controller_byte_packer.sv
// byte_packer
// Collects bytes little-endian into 32-bit words. The first three bytes
// are shifted into a 24-bit accumulator; the fourth byte is combined with
// it combinationally so the full word is available in the accepting cycle.
//   clk, rst_n   clock, async active-low reset
//   clear        drop any partial word
//   byte_valid   byte accepted this cycle
//   byte_data    the byte
//   word_valid   high in the cycle the 4th byte is accepted
//   word         packed word (valid with word_valid)
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt;
    logic [23:0] acc;

    assign word_valid = byte_valid && (cnt == 2'd3);
    // Shifting right means byte 0 ends up in [7:0] after three shifts.
    assign word       = {byte_data, acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (clear) begin
            cnt <= '0;
            acc <= '0;
        end else if (byte_valid) begin
            acc <= {byte_data, acc[23:8]};
            cnt <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/run_controller.sv
// run_controller
// Sequences a single-cycle RV32I core through program load, free run,
// single step and halt. Loader bytes are packed into instruction-memory
// writes; the core is gated via core_en and held at PC = 0 via core_rst_n
// while idle or loading. Halts on its own when ECALL/EBREAK is fetched.
//   CLK, reset      clock, async active-low reset
//   host            command + loader channels (run_controller_if.slave)
//   imem_we/waddr/wdata  registered instruction-memory write port
//   instr           instruction currently fetched by the core
//   core_en         PC / register-file / data-memory write enable
//   core_rst_n      registered core reset, low in IDLE and LOAD
//   state_o         current state
//   halted          sticky, set on ECALL/EBREAK
//   cycle_cnt       cycles spent in RUN/STEP
//   retired_cnt     cycles with core_en = 1
//
// state | meaning
// IDLE  | core held in reset, waiting for a command
// LOAD  | receiving program bytes, writing IMEM word by word
// RUN   | core free-running until ECALL/EBREAK or HALT command
// STEP  | core runs exactly one cycle
// HALT  | core stopped but out of reset, PC preserved
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             reset,
    run_controller_if.slave  host,
    output logic             imem_we,
    output logic [31:0]      imem_waddr,
    output logic [31:0]      imem_wdata,
    input  logic [31:0]      instr,
    output logic             core_en,
    output logic             core_rst_n,
    output logic [2:0]       state_o,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);
    localparam int LDW_W = $clog2(IMEM_WORDS) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [LDW_W-1:0] idx;
    logic [LDW_W-1:0] words;
    logic [LDW_W-1:0] idx_inc;
    logic [LDW_W-1:0] words_sat;
    logic             cmd_fire;
    logic             ld_fire;
    logic             is_sys;
    logic             ld_start;
    logic             last_word;
    logic             word_valid;
    logic [31:0]      word;
    logic             running;

    assign host.cmd_ready = (state != ST_LOAD);
    assign host.ld_ready  = (state == ST_LOAD);
    assign cmd_fire       = host.cmd_valid && host.cmd_ready;
    assign ld_fire        = host.ld_valid && host.ld_ready;
    assign is_sys         = is_sys_instr(instr);
    assign running        = (state == ST_RUN) || (state == ST_STEP);
    assign core_en        = running && !is_sys;
    assign state_o        = state;

    assign words_sat = (host.ld_words > LDW_W'(IMEM_WORDS)) ? LDW_W'(IMEM_WORDS)
                                                             : host.ld_words;
    assign ld_start  = cmd_fire && (host.cmd == CMD_LOAD) && (host.ld_words != '0)
                       && ((state == ST_IDLE) || (state == ST_HALT));
    assign idx_inc   = idx + LDW_W'(1);
    assign last_word = (state == ST_LOAD) && word_valid && (idx_inc == words);

    byte_packer u_packer (
        .clk        (CLK),
        .rst_n      (reset),
        .clear      (ld_start),
        .byte_valid (ld_fire),
        .byte_data  (host.ld_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (cmd_fire) begin
                    case (host.cmd)
                        CMD_LOAD: if (ld_start) state_nxt = ST_LOAD;
                        CMD_RUN:  state_nxt = ST_RUN;
                        CMD_STEP: state_nxt = ST_STEP;
                        default:  state_nxt = state;
                    endcase
                end
            end
            ST_LOAD: if (last_word) state_nxt = ST_IDLE;
            // A HALT accepted in RUN lets the current instruction retire.
            ST_RUN:  if (is_sys || (cmd_fire && host.cmd == CMD_HALT)) state_nxt = ST_HALT;
            ST_STEP: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            words       <= '0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
            core_rst_n  <= 1'b0;
            halted      <= 1'b0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            state      <= state_nxt;
            core_rst_n <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP)
                          || (state_nxt == ST_HALT);
            imem_we    <= 1'b0;

            if (ld_start) begin
                idx         <= '0;
                words       <= words_sat;
                cycle_cnt   <= '0;
                retired_cnt <= '0;
                halted      <= 1'b0;
            end

            if ((state == ST_LOAD) && word_valid) begin
                imem_we    <= 1'b1;
                imem_waddr <= {{(30-LDW_W){1'b0}}, idx, 2'b00};
                imem_wdata <= word;
                idx        <= idx_inc;
            end

            if (running) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
                if (core_en) retired_cnt <= retired_cnt + CNT_W'(1);
                if (is_sys)  halted      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;
    import run_ctrl_pkg::*;

    localparam int IMEM_WORDS = 256;
    localparam int CNT_W      = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             CLK;
    logic             reset;
    logic             imem_we;
    logic [31:0]      imem_waddr;
    logic [31:0]      imem_wdata;
    logic [31:0]      instr;
    logic             core_en;
    logic             core_rst_n;
    logic [2:0]       state_o;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retired_cnt;

    run_controller_if #(.IMEM_WORDS(IMEM_WORDS)) bus ();

    run_controller #(.IMEM_WORDS(IMEM_WORDS), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .host        (bus),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .instr       (instr),
        .core_en     (core_en),
        .core_rst_n  (core_rst_n),
        .state_o     (state_o),
        .halted      (halted),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    int          en_cnt = 0;
    int          en_base;
    logic [31:0] last_addr = '0;
    logic [63:0] exp_q[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: counts core_en cycles and checks every IMEM write
    // against the queue of expected {addr, data} pairs.
    task automatic monitor();
        forever begin
            @(negedge CLK);
            if (core_en === 1'b1) en_cnt++;
            if (imem_we === 1'b1) begin
                logic [63:0] e;
                last_addr = imem_waddr;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             imem_waddr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("imem_write", {imem_waddr, imem_wdata}, e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(cmd_t c, logic [8:0] w);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.ld_words  = w;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_byte(logic [7:0] b);
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic load_word(logic [8:0] i, logic [31:0] w);
        exp_q.push_back({21'd0, i, 2'b00, w});
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    initial begin
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = CMD_LOAD;
        bus.ld_words  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        instr         = NOP;
        fork
            monitor();
        join_none

        // reset values
        #12;
        check("rst_state",      64'(state_o), 0);
        check("rst_core_rst_n", 64'(core_rst_n), 0);
        check("rst_imem",       {31'd0, imem_we, imem_waddr}, 0);
        check("rst_imem_wdata", 64'(imem_wdata), 0);
        check("rst_halted",     64'(halted), 0);
        check("rst_counters",   {cycle_cnt, retired_cnt}, 0);
        check("rst_ready",      {62'd0, bus.cmd_ready, bus.ld_ready}, 2);
        reset = 1'b1;
        tick();

        // two-word load
        send_cmd(CMD_LOAD, 9'd2);
        check("load_state", 64'(state_o), 1);
        check("load_ready", {62'd0, bus.cmd_ready, bus.ld_ready}, 1);
        load_word(9'd0, 32'h0050_0013);
        check("load_core_rst_n_mid", 64'(core_rst_n), 0);
        load_word(9'd1, 32'h00A0_0093);
        tick();
        check("load_done_state", 64'(state_o), 0);
        check("load_done_core_rst_n", 64'(core_rst_n), 0);

        // run 5 NOPs then ECALL
        en_base = en_cnt;
        instr = NOP;
        send_cmd(CMD_RUN, 9'd0);
        check("run_core_rst_n", 64'(core_rst_n), 1);
        repeat (5) tick();
        instr = INSTR_ECALL;
        tick();
        check("ecall_state",   64'(state_o), 4);
        check("ecall_halted",  64'(halted), 1);
        check("ecall_retired", 64'(retired_cnt), 5);
        check("ecall_cycles",  64'(cycle_cnt), 6);
        check("ecall_en_cyc",  64'(en_cnt - en_base), 5);
        check("ecall_core_en", 64'(core_en), 0);

        // two single steps
        instr = NOP;
        en_base = en_cnt;
        send_cmd(CMD_STEP, 9'd0);
        check("step_state", 64'(state_o), 3);
        tick();
        check("step_back_halt", 64'(state_o), 4);
        send_cmd(CMD_STEP, 9'd0);
        tick();
        check("step2_state",   64'(state_o), 4);
        check("step2_en_cyc",  64'(en_cnt - en_base), 2);
        check("step2_retired", 64'(retired_cnt), 7);
        check("step2_cycles",  64'(cycle_cnt), 8);

        // RUN while parked on ECALL re-halts at once
        instr = INSTR_ECALL;
        en_base = en_cnt;
        send_cmd(CMD_RUN, 9'd0);
        tick();
        check("rehalt_state",   64'(state_o), 4);
        check("rehalt_retired", 64'(retired_cnt), 7);
        check("rehalt_cycles",  64'(cycle_cnt), 9);
        check("rehalt_en_cyc",  64'(en_cnt - en_base), 0);

        // RUN, HALT command accepted in the 3rd cycle
        instr = NOP;
        en_base = en_cnt;
        send_cmd(CMD_RUN, 9'd0);
        repeat (2) tick();
        send_cmd(CMD_HALT, 9'd0);
        check("haltcmd_state", 64'(state_o), 4);
        repeat (3) tick();
        check("haltcmd_en_cyc",  64'(en_cnt - en_base), 3);
        check("haltcmd_retired", 64'(retired_cnt), 10);
        check("haltcmd_cycles",  64'(cycle_cnt), 12);

        // reset in the middle of a word
        send_cmd(CMD_LOAD, 9'd1);
        check("reload_state",   64'(state_o), 1);
        check("reload_core_rst", 64'(core_rst_n), 0);
        check("reload_cleared", {cycle_cnt, retired_cnt}, 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b0;
        #3;
        check("midrst_state", 64'(state_o), 0);
        check("midrst_we",    64'(imem_we), 0);
        tick();
        reset = 1'b1;
        tick();
        // byte strobe outside LOAD must be ignored
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hFF;
        send_cmd(CMD_HALT, 9'd0);
        bus.ld_valid = 1'b0;
        check("stray_state", 64'(state_o), 0);
        send_cmd(CMD_LOAD, 9'd1);
        load_word(9'd0, 32'h4433_2211);
        tick();
        check("fresh_state", 64'(state_o), 0);

        // zero-length load is a no-op
        send_cmd(CMD_LOAD, 9'd0);
        check("zero_state", 64'(state_o), 0);
        repeat (2) tick();

        // oversized load saturates at IMEM_WORDS
        send_cmd(CMD_LOAD, 9'(IMEM_WORDS + 5));
        for (int i = 0; i < IMEM_WORDS; i++) begin
            logic [7:0] b;
            b = 8'(i);
            load_word(9'(i), {~b, b, 8'hC3, b});
        end
        tick();
        check("sat_state",     64'(state_o), 0);
        check("sat_last_addr", 64'(last_addr), 64'((IMEM_WORDS - 1) * 4));
        check("sat_cmd_ready", 64'(bus.cmd_ready), 1);

        repeat (2) tick();
        check("queue_empty", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Sequences the single-cycle RV32I core (`Procesador`) through program loading, free-running execution, single-stepping and halting.
- Receives a byte stream from a host/loader and packs it little-endian into 32-bit words written to instruction memory.
- Gates core execution through a core enable (`core_en`), which freezes the PC and the register-file and data-memory writes.
- Holds the PC at 0 while the program image is being loaded.
- Counts cycles and retired instructions, and halts automatically on ECALL/EBREAK.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- CNT_W, 32, width of the cycle and retired counters.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command strobe.
- cmd  in  2  command: 00 LOAD, 01 RUN, 10 STEP, 11 HALT.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- ld_words  in  $clog2(IMEM_WORDS)+1  word count, sampled with the LOAD command.
- ld_valid  in  1  loader byte strobe.
- ld_data  in  8  loader byte.
- ld_ready  out  1  byte accepted when ld_valid && ld_ready.
- imem_we  out  1  instruction memory write enable.
- imem_waddr  out  32  byte address (word index * 4).
- imem_wdata  out  32  packed instruction word.
- instr  in  32  instruction currently fetched by the core.
- core_en  out  1  enables PC update, RUWr and DMWr.
- core_rst_n  out  1  active-low reset to PC/core; low holds PC = 0.
- state_o  out  3  current FSM state.
- halted  out  1  sticky; set when the core stops on ECALL/EBREAK.
- cycle_cnt  out  CNT_W  cycles spent in RUN/STEP.
- retired_cnt  out  CNT_W  cycles with core_en = 1.

Behaviour:
- Reset (async, reset = 0) sets every register output as follows:
  - state = IDLE; counters = 0; halted = 0.
  - imem_we = 0, imem_waddr = 0, imem_wdata = 0.
  - core_rst_n = 0.
  - Any partial word being assembled is discarded; IMEM contents are untouched.
- States: IDLE, LOAD, RUN, STEP, HALT.
- core_rst_n is registered: 0 in IDLE and LOAD, 1 in RUN, STEP and HALT.
- cmd_ready = (state != LOAD); ld_ready = (state == LOAD).
- is_sys = (instr == 32'h0000_0073) || (instr == 32'h0010_0073).
- core_en is combinational: (state == RUN || state == STEP) && !is_sys.
- IDLE:
  - LOAD with ld_words != 0 → LOAD. Word index, byte count, cycle_cnt, retired_cnt and halted are cleared; the count saturates at IMEM_WORDS.
  - LOAD with ld_words == 0 is accepted as a no-op.
  - RUN → RUN; STEP → STEP; HALT is a no-op.
- LOAD:
  - Each accepted byte fills the assembly register little-endian: byte 0 → [7:0], ..., byte 3 → [31:24].
  - On the cycle the 4th byte is accepted, imem_we = 1 is registered for exactly the next cycle, with imem_waddr = idx*4 and imem_wdata = the packed word. idx then increments.
  - After the write for the final word, the next state is IDLE.
  - Commands are not accepted (cmd_ready = 0).
- RUN:
  - cycle_cnt increments every cycle; retired_cnt increments when core_en = 1.
  - If is_sys: core_en = 0 that cycle, the PC stays on the ECALL, the next state is HALT, and halted is set.
  - HALT command: the instruction in the accepting cycle still executes; the next state is HALT.
  - LOAD, RUN and STEP commands are accepted as no-ops.
- STEP:
  - Exactly one cycle with core_en = 1 (unless is_sys, which also sets halted).
  - Always → HALT next.
- HALT:
  - core_en = 0.
  - RUN → RUN; STEP → STEP; LOAD → LOAD (core_rst_n drops, so the PC returns to 0).
  - HALT is a no-op.
  - RUN or STEP while still sitting on an ECALL re-halts immediately; retired_cnt does not change, cycle_cnt advances by 1.
- Counters wrap modulo 2^CNT_W.
- Simultaneous cmd_valid and ld_valid outside LOAD: the byte is ignored (ld_ready = 0).

Decomposition:
- Shared package run_ctrl_pkg:
  - state_t enum (IDLE = 0, LOAD = 1, RUN = 2, STEP = 3, HALT = 4).
  - cmd_t enum.
  - Constants INSTR_ECALL = 32'h0000_0073 and INSTR_EBREAK = 32'h0010_0073.
- One sub-module, byte_packer: byte counter plus the 32-bit shift/assembly register; emits word_valid and word.

Test Plan:
- Load 2 words: bytes 13,00,50,00,93,00,A0,00 with ld_words = 2 → exactly two one-cycle imem_we pulses:
  - 0x0000 ← 32'h00500013.
  - 0x0004 ← 32'h00A00093.
  - Then state = IDLE and core_rst_n = 0 throughout.
- RUN with instr = 32'h00000013 for 5 cycles, then instr = 32'h00000073 → core_en high for 5 cycles then low. Expected: state = HALT, halted = 1, retired_cnt = 5, cycle_cnt = 6.
- From HALT, issue STEP twice with instr = NOP → core_en high for exactly 1 cycle each time, retired_cnt += 2, state returns to HALT.
- RUN, then a HALT command on cycle 3 → core_en high in cycles 1–3, low afterwards, retired_cnt = 3.
- Assert reset low after byte 2 of a LOAD → no imem_we pulse, state = IDLE. A subsequent LOAD of 1 word packs from byte 0 (no stale bytes).
- LOAD with ld_words = 0 → no state change and no writes; ld_words = IMEM_WORDS + 5 → saturates, last write address = (IMEM_WORDS − 1)*4.
